// File: rtl/pmu_sipo_sequencer_if.sv
// Host/loader signal bundle for the PMU SIPO sequencer.
// Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
// ready never depends on valid, and the source must hold valid and its payload steady until it completes.
interface pmu_sipo_sequencer_if #(
  parameter int LEN_WIDTH = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [3:0]           cmd_op;
  logic [LEN_WIDTH-1:0] cmd_len;
  logic                 bit_valid;
  logic                 bit_ready;
  logic                 bit_data;
  logic                 abort;
  logic                 sipo_en;
  logic                 sipo_send;
  logic [3:0]           sipo_instr;
  logic                 sipo_data;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic                 key_locked;

  modport master (
    output cmd_valid, cmd_op, cmd_len, bit_valid, bit_data, abort,
    input  cmd_ready, bit_ready, sipo_en, sipo_send, sipo_instr, sipo_data,
           busy, done, err, key_locked
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, bit_valid, bit_data, abort,
    output cmd_ready, bit_ready, sipo_en, sipo_send, sipo_instr, sipo_data,
           busy, done, err, key_locked
  );
endinterface

// File: rtl/pmu_sipo_sequencer.sv
// Command-driven sequencer that streams serial bits into the PMU SIPO loader,
// with per-target length limits and a one-time key-load lock.
module pmu_sipo_sequencer #(
  parameter int AES_DATA_WIDTH = 128,
  parameter int MEM_DATA_WIDTH = 32,
  parameter int KEY_DATA_WIDTH = 128,
  parameter int LEN_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  pmu_sipo_sequencer_if.slave  bus,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [LEN_WIDTH-1:0] remaining;
  logic [LEN_WIDTH-1:0] limit;
  logic [3:0]           instr_q;
  logic                 err_q;
  logic                 lock_q;
  logic                 cmd_legal;
  logic                 accept_cmd;
  logic                 accept_bit;
  logic                 last_bit;

  always_comb begin
    limit = '0;
    case (bus.cmd_op)
      4'd0, 4'd2: limit = LEN_WIDTH'(AES_DATA_WIDTH);
      4'd1:       limit = LEN_WIDTH'(MEM_DATA_WIDTH);
      4'd3:       limit = LEN_WIDTH'(KEY_DATA_WIDTH);
      default:    limit = '0;
    endcase
  end

  assign cmd_legal  = (bus.cmd_op <= 4'd3) && (bus.cmd_len != '0) && (bus.cmd_len <= limit) &&
                      !((bus.cmd_op == 4'd3) && lock_q);
  assign accept_cmd = (state == S_IDLE) && bus.cmd_valid && cmd_legal;
  // abort blocks acceptance, so an aborted final bit never reaches the loader
  assign accept_bit = (state == S_SHIFT) && bus.bit_valid && !bus.abort;
  assign last_bit   = (remaining == LEN_WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept_cmd) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (bus.abort)                   state_nxt = S_IDLE;
        else if (accept_bit && last_bit) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= '0;
      instr_q   <= '0;
      err_q     <= 1'b0;
      lock_q    <= 1'b0;
    end else begin
      err_q <= ((state == S_IDLE) && bus.cmd_valid && !cmd_legal) ||
               ((state == S_SHIFT) && bus.abort);
      if (accept_cmd) begin
        remaining <= bus.cmd_len;
        instr_q   <= bus.cmd_op;
      end else if (accept_bit) begin
        remaining <= remaining - LEN_WIDTH'(1);
      end else if ((state == S_SHIFT) && bus.abort) begin
        remaining <= '0;
      end
      if ((state == S_DONE) && (instr_q == 4'd3)) lock_q <= 1'b1;
    end
  end

  assign bus.cmd_ready  = (state == S_IDLE);
  assign bus.bit_ready  = (state == S_SHIFT) && !bus.abort;
  assign bus.sipo_en    = accept_bit;
  assign bus.sipo_data  = (state == S_SHIFT) ? bus.bit_data : 1'b0;
  assign bus.sipo_send  = accept_bit && last_bit;
  assign bus.sipo_instr = instr_q;
  assign bus.busy       = (state != S_IDLE);
  assign bus.done       = (state == S_DONE);
  assign bus.err        = err_q;
  assign bus.key_locked = lock_q;
  assign state_dbg      = state;

endmodule
